// File: rtl/axis_vid_out_gen2_pkg.sv
// Shared types for the AXI4-Stream to video output bridge.
// FSM state encoding, FIFO side-band tag, statistics counter width.
package axis_vid_out_gen2_pkg;

   typedef enum logic [1:0] {
      ST_FLUSH      = 2'd0,
      ST_WAIT_VSYNC = 2'd1,
      ST_LOCKED     = 2'd2
   } state_t;

   // Side-band bits stored above tdata in every FIFO entry
   typedef struct packed {
      logic sof;
      logic eol;
   } fifo_tag_t;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/axis_vid_out_gen2_if.sv
// AXI4-Stream video bundle; master drives pixels, slave returns tready.
interface axis_vid_out_gen2_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tuser;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_vid_out_gen2_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy output.
// Push/pop requests are ignored when full/empty respectively.
module axis_vid_out_gen2_fifo #(
   parameter int W         = 18,
   parameter int ADDR_BITS = 10
) (
   input  logic                 aclk,
   input  logic                 rst,
   input  logic                 i_push,
   input  logic [W-1:0]         i_wdata,
   input  logic                 i_pop,
   output logic [W-1:0]         o_rdata,
   output logic [ADDR_BITS:0]   o_level,
   output logic                 o_empty,
   output logic                 o_full
);
   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

   logic [W-1:0]           r_mem [DEPTH];
   logic [ADDR_BITS-1:0]   r_wr_ptr;
   logic [ADDR_BITS-1:0]   r_rd_ptr;
   logic [ADDR_BITS:0]     r_level;
   logic                   w_push;
   logic                   w_pop;

   assign o_full  = (r_level == DEPTH_L);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge aclk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/axis_vid_out_gen2.sv
// AXI4-Stream to timed video output with SOF-aligned lock and underflow recovery.
// Optional statistics counters: define AXIS_VID_OUT_GEN2_STATS_EN.
//
// state         | meaning
// ST_FLUSH      | discard FIFO head until a start-of-frame pixel sits at the head
// ST_WAIT_VSYNC | SOF at head; lock on next vsync rise once FIFO has enough margin
// ST_LOCKED     | one pixel popped per active-video cycle
module axis_vid_out_gen2
   import axis_vid_out_gen2_pkg::*;
#(
   parameter int DATA_WIDTH       = 16,
   parameter int ADDR_BITS        = 10,
   parameter int HYSTERESIS_LEVEL = 12
) (
   input  logic                  aclk,
   input  logic                  rst,
   input  logic                  aclken,
   axis_vid_out_gen2_if.slave    s_axis_video,
   input  logic                  vtg_vsync,
   input  logic                  vtg_hsync,
   input  logic                  vtg_vblank,
   input  logic                  vtg_hblank,
   input  logic                  vtg_act_vid,
   output logic                  vtg_ce,
   output logic                  vtg_fsync,
   output logic                  video_de,
   output logic                  video_vsync,
   output logic                  video_hsync,
   output logic                  video_vblank,
   output logic                  video_hblank,
   output logic [DATA_WIDTH-1:0] video_data,
   output logic                  locked,
   output logic                  wr_error,
   output logic                  underflow,
   output logic                  empty,
   output logic [ADDR_BITS:0]    fifo_level,
   output logic [CNT_W-1:0]      underflow_cnt,
   output logic [CNT_W-1:0]      frame_cnt
);
   localparam int FW = DATA_WIDTH + 2;
   localparam logic [ADDR_BITS:0] HYST_L = (ADDR_BITS+1)'(HYSTERESIS_LEVEL);

   state_t                r_state, w_nxt;
   logic                  r_vsync_d, r_sof_pending;
   logic [FW-1:0]         w_head;
   fifo_tag_t             w_head_tag;
   logic                  w_full, w_empty, w_push, w_pop;
   logic [ADDR_BITS:0]    w_level;
   logic                  w_vs_edge, w_fsync, w_uf, w_err, w_de;
   logic [DATA_WIDTH-1:0] w_data;

   assign s_axis_video.tready = aclken & ~w_full & ~rst;
   assign w_push     = s_axis_video.tvalid & s_axis_video.tready;
   assign w_head_tag = w_head[FW-1 -: 2];
   assign w_vs_edge  = vtg_vsync & ~r_vsync_d;
   assign vtg_ce     = aclken;
   assign empty      = w_empty;
   assign fifo_level = w_level;
   assign locked     = (r_state == ST_LOCKED);

   axis_vid_out_gen2_fifo #(.W(FW), .ADDR_BITS(ADDR_BITS)) u_fifo (
      .aclk    (aclk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata ({s_axis_video.tuser, s_axis_video.tlast, s_axis_video.tdata}),
      .i_pop   (w_pop & aclken),
      .o_rdata (w_head),
      .o_level (w_level),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_comb begin
      w_nxt   = r_state;
      w_pop   = 1'b0;
      w_fsync = 1'b0;
      w_uf    = 1'b0;
      w_err   = 1'b0;
      w_de    = 1'b0;
      w_data  = '0;
      case (r_state)
         ST_FLUSH: begin
            if (!w_empty) begin
               if (w_head_tag.sof) w_nxt = ST_WAIT_VSYNC;
               else                w_pop = 1'b1;
            end
         end
         ST_WAIT_VSYNC: begin
            if (w_vs_edge && (w_level >= HYST_L)) begin
               w_nxt   = ST_LOCKED;
               w_fsync = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (vtg_act_vid) begin
               w_de = 1'b1;
               if (w_empty) begin
                  w_uf  = 1'b1;
                  w_nxt = ST_FLUSH;
               end else begin
                  w_pop  = 1'b1;
                  w_data = w_head[DATA_WIDTH-1:0];
                  // SOF must appear exactly on the first pixel after vsync
                  if (w_head_tag.sof != r_sof_pending) begin
                     w_err = 1'b1;
                     w_nxt = ST_FLUSH;
                  end
               end
            end
         end
         default: w_nxt = ST_FLUSH;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         r_state       <= ST_FLUSH;
         r_vsync_d     <= 1'b0;
         r_sof_pending <= 1'b0;
         vtg_fsync     <= 1'b0;
         video_de      <= 1'b0;
         video_vsync   <= 1'b0;
         video_hsync   <= 1'b0;
         video_vblank  <= 1'b0;
         video_hblank  <= 1'b0;
         video_data    <= '0;
         wr_error      <= 1'b0;
         underflow     <= 1'b0;
      end else if (aclken) begin
         r_state   <= w_nxt;
         r_vsync_d <= vtg_vsync;
         if (w_fsync || ((r_state == ST_LOCKED) && w_vs_edge)) r_sof_pending <= 1'b1;
         else if (w_pop)                                        r_sof_pending <= 1'b0;
         vtg_fsync    <= w_fsync;
         video_de     <= w_de;
         video_vsync  <= vtg_vsync;
         video_hsync  <= vtg_hsync;
         video_vblank <= vtg_vblank;
         video_hblank <= vtg_hblank;
         video_data   <= w_data;
         wr_error     <= w_err;
         underflow    <= w_uf;
      end
   end

`ifdef AXIS_VID_OUT_GEN2_STATS_EN
   logic [CNT_W-1:0] r_uf_cnt, r_frame_cnt;

   always_ff @(posedge aclk) begin
      if (rst) begin
         r_uf_cnt    <= '0;
         r_frame_cnt <= '0;
      end else if (aclken) begin
         if (w_uf)    r_uf_cnt    <= sat_inc(r_uf_cnt);
         if (w_fsync) r_frame_cnt <= sat_inc(r_frame_cnt);
      end
   end

   assign underflow_cnt = r_uf_cnt;
   assign frame_cnt     = r_frame_cnt;
`else
   assign underflow_cnt = '0;
   assign frame_cnt     = '0;
`endif

endmodule

// File: tb/tb_axis_vid_out_gen2.sv
// Directed scenarios with random pixel data for axis_vid_out_gen2;
// expected pixel order is kept in a queue of what the stream should deliver.
module tb_axis_vid_out_gen2;
   localparam int DW    = 16;
   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;

   logic aclk = 1'b0;
   logic rst, aclken;
   logic vtg_vsync, vtg_hsync, vtg_vblank, vtg_hblank, vtg_act_vid;
   logic vtg_ce, vtg_fsync, video_de, video_vsync, video_hsync, video_vblank, video_hblank;
   logic [DW-1:0] video_data;
   logic locked, wr_error, underflow, empty;
   logic [AB:0] fifo_level;
   logic [15:0] underflow_cnt, frame_cnt;

   axis_vid_out_gen2_if #(.DATA_WIDTH(DW)) s_axis_video ();

   always #5 aclk = ~aclk;

   axis_vid_out_gen2 #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .HYSTERESIS_LEVEL(12)) dut (
      .aclk(aclk), .rst(rst), .aclken(aclken), .s_axis_video(s_axis_video),
      .vtg_vsync(vtg_vsync), .vtg_hsync(vtg_hsync), .vtg_vblank(vtg_vblank),
      .vtg_hblank(vtg_hblank), .vtg_act_vid(vtg_act_vid),
      .vtg_ce(vtg_ce), .vtg_fsync(vtg_fsync), .video_de(video_de),
      .video_vsync(video_vsync), .video_hsync(video_hsync),
      .video_vblank(video_vblank), .video_hblank(video_hblank),
      .video_data(video_data), .locked(locked), .wr_error(wr_error),
      .underflow(underflow), .empty(empty), .fifo_level(fifo_level),
      .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int exp_frames = 0;
   int exp_uf = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] px;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cexp(input int v);
`ifdef AXIS_VID_OUT_GEN2_STATS_EN
      return v[15:0];
`else
      return 16'd0 + 16'(v * 0);
`endif
   endfunction

   task automatic push(input logic [DW-1:0] d, input logic sof);
      s_axis_video.tvalid = 1'b1;
      s_axis_video.tdata  = d;
      s_axis_video.tuser  = sof;
      s_axis_video.tlast  = 1'b0;
      chk("push_tready", s_axis_video.tready, 1);
      tick();
      s_axis_video.tvalid = 1'b0;
      s_axis_video.tuser  = 1'b0;
   endtask

   // One timing cycle with random sync/blank lines that must re-appear a cycle later
   task automatic vid(input logic act);
      logic h, vb, hb;
      h  = 1'($urandom);
      vb = 1'($urandom);
      hb = 1'($urandom);
      vtg_hsync   = h;
      vtg_vblank  = vb;
      vtg_hblank  = hb;
      vtg_act_vid = act;
      tick();
      chk("pass_hsync", video_hsync, h);
      chk("pass_vblank", video_vblank, vb);
      chk("pass_hblank", video_hblank, hb);
      chk("pass_vsync", video_vsync, 0);
      vtg_act_vid = 1'b0;
   endtask

   task automatic vsync_pulse(input logic exp_lock);
      vtg_vsync = 1'b1;
      tick();
      if (exp_lock) exp_frames++;
      chk("vs_locked", locked, exp_lock);
      chk("vs_fsync", vtg_fsync, exp_lock);
      chk("vs_vsync_out", video_vsync, 1);
      chk("frame_cnt", frame_cnt, cexp(exp_frames));
      vtg_vsync = 1'b0;
      tick();
      chk("vs_fsync_end", vtg_fsync, 0);
      chk("vs_locked_hold", locked, exp_lock);
   endtask

   task automatic play(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            vid(1'b0);
            chk("gap_de", video_de, 0);
            chk("gap_data", video_data, 0);
         end
         vid(1'b1);
         px = (q.size() > 0) ? q.pop_front() : '0;
         chk("px_de", video_de, 1);
         chk("px_data", video_data, px);
      end
   endtask

   initial begin
      rst = 1'b1; aclken = 1'b1;
      vtg_vsync = 0; vtg_hsync = 0; vtg_vblank = 0; vtg_hblank = 0; vtg_act_vid = 0;
      s_axis_video.tvalid = 0; s_axis_video.tdata = '0;
      s_axis_video.tuser = 0; s_axis_video.tlast = 0;

      // reset
      tick(); tick();
      chk("rst_tready", s_axis_video.tready, 0);
      rst = 1'b0;
      tick();
      chk("rst_locked", locked, 0);
      chk("rst_empty", empty, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_data", video_data, 0);
      chk("rst_de", video_de, 0);
      chk("rst_fsync", vtg_fsync, 0);
      chk("rst_uf", underflow, 0);
      chk("rst_err", wr_error, 0);
      chk("rst_ufcnt", underflow_cnt, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("vtg_ce_on", vtg_ce, 1);

      // basic lock and playout of 16 pixels
      for (int i = 0; i < 16; i++) begin
         px = DW'($urandom);
         q.push_back(px);
         push(px, i == 0);
      end
      chk("lvl16", fifo_level, 16);
      vsync_pulse(1'b1);
      play(16);
      chk("drained_empty", empty, 1);

      // underflow: 4 queued, 8 active cycles
      for (int i = 0; i < 4; i++) begin
         px = DW'($urandom);
         q.push_back(px);
         push(px, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         vid(1'b1);
         if (i < 4) begin
            px = q.pop_front();
            chk("uf_px_data", video_data, px);
            chk("uf_px_locked", locked, 1);
            chk("uf_px_pulse", underflow, 0);
         end else if (i == 4) begin
            exp_uf++;
            chk("uf_pulse", underflow, 1);
            chk("uf_data", video_data, 0);
            chk("uf_locked", locked, 0);
            chk("uf_cnt", underflow_cnt, cexp(exp_uf));
         end else begin
            chk("uf_pulse_end", underflow, 0);
            chk("uf_de_after", video_de, 0);
         end
      end

      // 3 non-SOF pixels flushed, SOF retained, hysteresis gate at 11 vs 12
      for (int i = 0; i < 3; i++) push(DW'($urandom), 1'b0);
      for (int i = 0; i < 11; i++) begin
         px = DW'($urandom);
         q.push_back(px);
         push(px, i == 0);
      end
      tick(); tick();
      chk("lvl11", fifo_level, 11);
      vsync_pulse(1'b0);
      px = DW'($urandom);
      q.push_back(px);
      push(px, 1'b0);
      chk("lvl12", fifo_level, 12);
      vsync_pulse(1'b1);
      play(12);

      // stray SOF mid-line
      for (int i = 0; i < 3; i++) begin
         px = DW'($urandom);
         q.push_back(px);
         push(px, 1'b0);
      end
      push(DW'($urandom), 1'b1);
      push(DW'($urandom), 1'b0);
      push(DW'($urandom), 1'b0);
      for (int i = 0; i < 13; i++) begin
         px = DW'($urandom);
         if (i == 0) q.push_back(px);
         push(px, i == 0);
      end
      for (int i = 0; i < 3; i++) begin
         vid(1'b1);
         px = q.pop_front();
         chk("err_px_data", video_data, px);
         chk("err_px_noerr", wr_error, 0);
      end
      vid(1'b1);
      chk("err_pulse", wr_error, 1);
      chk("err_locked", locked, 0);
      vid(1'b0);
      chk("err_pulse_end", wr_error, 0);
      tick(); tick(); tick();
      chk("err_lvl13", fifo_level, 13);
      vsync_pulse(1'b1);
      play(1);
      q.delete();

      // fill to full, freeze with aclken=0, then mid-frame reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frames = 0;
      exp_uf = 0;
      s_axis_video.tvalid = 1'b1;
      for (int i = 0; i < DEPTH + 6; i++) begin
         s_axis_video.tdata = DW'($urandom);
         s_axis_video.tuser = (i == 0);
         tick();
      end
      chk("full_tready", s_axis_video.tready, 0);
      chk("full_level", fifo_level, DEPTH);
      chk("full_empty", empty, 0);
      s_axis_video.tvalid = 1'b0;
      vtg_hsync = 1; vtg_vblank = 1; vtg_hblank = 0; vtg_vsync = 0; vtg_act_vid = 0;
      tick();
      aclken = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vtg_vsync = 1; vtg_hsync = 0; vtg_vblank = 0; vtg_hblank = 1; vtg_act_vid = 1;
         s_axis_video.tvalid = 1'b1;
         tick();
         chk("frz_hsync", video_hsync, 1);
         chk("frz_vblank", video_vblank, 1);
         chk("frz_hblank", video_hblank, 0);
         chk("frz_vsync", video_vsync, 0);
         chk("frz_de", video_de, 0);
         chk("frz_locked", locked, 0);
         chk("frz_level", fifo_level, DEPTH);
         chk("frz_ce", vtg_ce, 0);
         chk("frz_tready", s_axis_video.tready, 0);
      end
      s_axis_video.tvalid = 1'b0;
      vtg_vsync = 0; vtg_act_vid = 0; vtg_hblank = 0;
      aclken = 1'b1;
      rst = 1'b1;
      vtg_vsync = 1; vtg_hsync = 1;
      #1;
      chk("mid_rst_tready", s_axis_video.tready, 0);
      tick();
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_hsync", video_hsync, 0);
      chk("mid_rst_vsync", video_vsync, 0);
      chk("mid_rst_data", video_data, 0);
      chk("mid_rst_fsync", vtg_fsync, 0);
      chk("mid_rst_fcnt", frame_cnt, 0);
      rst = 1'b0;
      vtg_vsync = 0; vtg_hsync = 0;
      tick();
      for (int i = 0; i < 12; i++) push(DW'($urandom), 1'b0);
      tick(); tick();
      chk("nosof_level", fifo_level, 0);
      vsync_pulse(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axis_vid_out_gen2.md
AXIS_VID_OUT_GEN2 -- requirements
Module: axis_vid_out_gen2

Interface
REQ-001 Param DATA_WIDTH, 16, pixel bits on tdata and video_data (8..64, multiple of 8).
REQ-002 Param ADDR_BITS, 10, FIFO depth = 2**ADDR_BITS entries.
REQ-003 Param HYSTERESIS_LEVEL, 12, minimum FIFO level required before arming on vsync.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 aclken  in  1  global clock enable.
REQ-007 s_axis_video_tdata/tvalid/tready/tuser/tlast  in/in/out/in/in  DATA_WIDTH/1/1/1/1  AXI4-Stream video slave; tuser=SOF, tlast=EOL.
REQ-008 vtg_vsync/hsync/vblank/hblank/act_vid  in  1 each  timing from external generator.
REQ-009 vtg_ce  out  1  timing generator enable; vtg_fsync  out  1  frame-sync pulse to generator.
REQ-010 video_de/vsync/hsync/vblank/hblank  out  1 each; video_data  out  DATA_WIDTH.
REQ-011 locked  out  1; wr_error  out  1 pulse; underflow  out  1 pulse; empty  out  1; fifo_level  out  ADDR_BITS+1.
REQ-012 underflow_cnt  out  16; frame_cnt  out  16 (statistics, see Configuration).

Function
REQ-013 FIFO SHALL store {tuser, tlast, tdata}; push on tvalid&tready&aclken.
REQ-014 tready SHALL be aclken & ~full (full from registered level; no same-cycle pop credit).
REQ-015 fifo_level SHALL equal entries held, correct under simultaneous push and pop.
REQ-016 When aclken=0 all state, FIFO and outputs SHALL hold; vtg_ce SHALL equal aclken.
REQ-017 FSM states: FLUSH, WAIT_VSYNC, LOCKED.
REQ-018 FLUSH: pop and discard head each cycle while head tuser=0; head tuser=1 -> WAIT_VSYNC without popping.
REQ-019 WAIT_VSYNC: on vtg_vsync rising edge with fifo_level >= HYSTERESIS_LEVEL -> LOCKED; vtg_fsync SHALL pulse 1 cycle on that transition.
REQ-020 LOCKED: pop one entry per cycle with vtg_act_vid=1; locked=1 only in LOCKED.
REQ-021 First active pixel after vsync SHALL carry tuser=1; any popped tuser mismatch (missing at frame start, present elsewhere) -> wr_error 1-cycle pulse, -> FLUSH.
REQ-022 vtg_act_vid=1 with FIFO empty in LOCKED -> underflow 1-cycle pulse, video_data=0 that cycle, -> FLUSH.
REQ-023 Video outputs SHALL be registered: exactly 1 cycle after the vtg inputs; video_de = act_vid & LOCKED; video_data = popped tdata when video_de else 0.
REQ-024 Sync/blank outputs SHALL follow vtg inputs in all states (timing passes through even unlocked).
REQ-025 empty SHALL be 1 when fifo_level=0.

Reset
REQ-026 rst SHALL override aclken.
REQ-027 After rst: state FLUSH, FIFO empty, fifo_level=0, tready=0 during rst, all video outputs 0, locked/wr_error/underflow/vtg_fsync=0, counters 0.
REQ-028 rst mid-frame SHALL discard FIFO contents; relock requires a new SOF.

Configuration
REQ-029 Macro AXIS_VID_OUT_GEN2_STATS_EN: defined -> underflow_cnt increments per underflow, frame_cnt per vtg_fsync, both saturating at 0xFFFF; undefined -> both ports tied 0, no counter logic.

Structure
REQ-030 Package axis_vid_out_gen2_pkg SHALL hold state enum, FIFO entry struct, counter width constant.
REQ-031 One sub-module axis_vid_out_gen2_fifo: synchronous single-clock FIFO with level output and first-word fall-through head.

Verification
REQ-032 Reset, push 16 pixels tuser on first, vsync edge -> locked=1 at next cycle, vtg_fsync one pulse, video_data follows act_vid by 1 cycle with pushed values.
REQ-033 Level 11 at vsync edge, HYSTERESIS_LEVEL=12 -> stays WAIT_VSYNC; next vsync with level 12 -> locks.
REQ-034 Locked, 8 act_vid cycles with 4 entries queued -> 4 pixels out, underflow pulse on 5th, video_data=0, locked=0, underflow_cnt=1 (with STATS_EN).
REQ-035 Stream 3 pixels without tuser then SOF -> FLUSH discards 3, head SOF retained, lock on next vsync.
REQ-036 Extra tuser mid-line while locked -> wr_error pulse, locked drops, FIFO flushed to next SOF.
REQ-037 Fill to 1024 entries with no act_vid -> tready=0, level=1024; aclken=0 for 5 cycles -> all outputs frozen; rst mid-frame -> REQ-027 values next cycle.
